// File: rtl/prism_sp_fifo_pkg.sv
// Shared definitions for the SP inter-stage FIFO bank.
//   fifo_count_width(depth) : width of occupancy counters / pointers for a
//                             channel of the given depth (one extra bit so
//                             full and empty are distinguishable).
//   MAX_NFIFOS, MAX_DEPTH   : legal upper limits for bank parameters.
//   fifo_op_e               : per-cycle accepted-operation code of a channel.
package prism_sp_fifo_pkg;

  localparam int MAX_NFIFOS = 16;
  localparam int MAX_DEPTH  = 1024;

  // Encoding is {write_accepted, read_accepted}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RW   = 2'b11
  } fifo_op_e;

  function automatic int fifo_count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/prism_sp_fifo_bank_if.sv
// Handshake/status bundle of the FIFO bank, one bit or word per channel.
//   master : the stage logic driving writes, reads, flush and err_clear.
//   slave  : the FIFO bank, returning data, status, counts and error flags.
interface prism_sp_fifo_bank_if
  import prism_sp_fifo_pkg::*;
#(
  parameter int NFIFOS     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int CW         = fifo_count_width(DEPTH)
);

  logic [NFIFOS-1:0]                 wr_en;
  logic [NFIFOS-1:0][DATA_WIDTH-1:0] wr_data;
  logic [NFIFOS-1:0]                 full;
  logic [NFIFOS-1:0]                 almost_full;
  logic [NFIFOS-1:0]                 rd_en;
  logic [NFIFOS-1:0][DATA_WIDTH-1:0] rd_data;
  logic [NFIFOS-1:0]                 empty;
  logic [NFIFOS-1:0]                 almost_empty;
  logic [NFIFOS-1:0][CW-1:0]         data_count;
  logic [NFIFOS-1:0]                 flush;
  logic [NFIFOS-1:0]                 err_clear;
  logic [NFIFOS-1:0]                 overflow;
  logic [NFIFOS-1:0]                 underflow;

  modport master (
    output wr_en, wr_data, rd_en, flush, err_clear,
    input  full, almost_full, rd_data, empty, almost_empty,
           data_count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, flush, err_clear,
    output full, almost_full, rd_data, empty, almost_empty,
           data_count, overflow, underflow
  );

endinterface

// File: rtl/prism_sp_fifo_chan.sv
// One first-word-fall-through FIFO channel.
//   clock, resetn       : clock and asynchronous active-low reset.
//   wr_en, wr_data      : write request (dropped when full or flushing).
//   rd_en, rd_data      : pop request; rd_data shows the head entry, 0 when empty.
//   flush               : synchronous clear of pointers and status.
//   err_clear           : clears the sticky overflow/underflow flags.
//   full, almost_full, empty, almost_empty, data_count : registered status.
//   overflow, underflow : sticky rejected-access flags.
module prism_sp_fifo_chan
  import prism_sp_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int CW         = fifo_count_width(DEPTH)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic                  err_clear,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [CW-1:0]         data_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = CW - 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         wr_ptr_n, rd_ptr_n, cnt_n;
  logic                  wr_acc, rd_acc;
  fifo_op_e              op;

  // Acceptance uses the registered status, so full/empty seen by the
  // requester this cycle are exactly what gate its request.
  always_comb begin
    wr_acc   = wr_en & ~full  & ~flush;
    rd_acc   = rd_en & ~empty & ~flush;
    op       = fifo_op_e'({wr_acc, rd_acc});
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    if (flush) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
    end else begin
      case (op)
        OP_WR:   wr_ptr_n = wr_ptr + 1'b1;
        OP_RD:   rd_ptr_n = rd_ptr + 1'b1;
        OP_RW: begin
          wr_ptr_n = wr_ptr + 1'b1;
          rd_ptr_n = rd_ptr + 1'b1;
        end
        default: ;
      endcase
    end
    cnt_n = wr_ptr_n - rd_ptr_n;
  end

  // Status is computed from next-state occupancy and registered, giving
  // status that reflects the state after each edge with no extra latency.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      data_count   <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= (AF_LEVEL == 0);
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_n;
      rd_ptr       <= rd_ptr_n;
      data_count   <= cnt_n;
      empty        <= (cnt_n == '0);
      full         <= (cnt_n == CW'(DEPTH));
      almost_empty <= (cnt_n <= CW'(AE_LEVEL));
      almost_full  <= (cnt_n >= CW'(AF_LEVEL));
      // Setting has priority over err_clear; flush suppresses new errors.
      if (wr_en && full && !flush)
        overflow <= 1'b1;
      else if (err_clear)
        overflow <= 1'b0;
      if (rd_en && empty && !flush)
        underflow <= 1'b1;
      else if (err_clear)
        underflow <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_acc)
      mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/prism_sp_fifo_bank.sv
// Bank of NFIFOS independent FWFT FIFO channels used as SP inter-stage
// buffering. Each channel is a prism_sp_fifo_chan; nothing is shared.
//   clock, resetn : common clock, asynchronous active-low reset.
//   bus (slave)   : per-channel wr_en/wr_data, rd_en/rd_data, flush,
//                   err_clear, full/almost_full, empty/almost_empty,
//                   data_count, overflow/underflow.
module prism_sp_fifo_bank
  import prism_sp_fifo_pkg::*;
#(
  parameter int NFIFOS     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int CW         = fifo_count_width(DEPTH)
) (
  input logic                clock,
  input logic                resetn,
  prism_sp_fifo_bank_if.slave bus
);

  if ((DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth_pow2
    $fatal(1, "prism_sp_fifo_bank: DEPTH must be a power of two");
  end
  if (DEPTH < 4 || DEPTH > MAX_DEPTH) begin : g_bad_depth_range
    $fatal(1, "prism_sp_fifo_bank: DEPTH out of range");
  end
  if (NFIFOS < 1 || NFIFOS > MAX_NFIFOS) begin : g_bad_nfifos
    $fatal(1, "prism_sp_fifo_bank: NFIFOS out of range");
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $fatal(1, "prism_sp_fifo_bank: AF_LEVEL exceeds DEPTH");
  end
  if (AE_LEVEL >= DEPTH) begin : g_bad_ae
    $fatal(1, "prism_sp_fifo_bank: AE_LEVEL must be below DEPTH");
  end
  if (CW != fifo_count_width(DEPTH)) begin : g_bad_cw
    $fatal(1, "prism_sp_fifo_bank: CW is derived from DEPTH");
  end

  for (genvar i = 0; i < NFIFOS; i++) begin : g_chan
    prism_sp_fifo_chan #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AF_LEVEL   (AF_LEVEL),
      .AE_LEVEL   (AE_LEVEL),
      .CW         (CW)
    ) u_chan (
      .clock        (clock),
      .resetn       (resetn),
      .wr_en        (bus.wr_en[i]),
      .wr_data      (bus.wr_data[i]),
      .rd_en        (bus.rd_en[i]),
      .flush        (bus.flush[i]),
      .err_clear    (bus.err_clear[i]),
      .rd_data      (bus.rd_data[i]),
      .full         (bus.full[i]),
      .almost_full  (bus.almost_full[i]),
      .empty        (bus.empty[i]),
      .almost_empty (bus.almost_empty[i]),
      .data_count   (bus.data_count[i]),
      .overflow     (bus.overflow[i]),
      .underflow    (bus.underflow[i])
    );
  end

endmodule

// File: tb/tb_prism_sp_fifo_bank.sv
module tb_prism_sp_fifo_bank;

  localparam int NF = 4;
  localparam int DW = 32;
  localparam int DP = 16;
  localparam int CW = 5;

  logic clock;
  logic resetn;
  int   ntests;
  int   nfail;

  prism_sp_fifo_bank_if #(.NFIFOS(NF), .DATA_WIDTH(DW), .DEPTH(DP), .CW(CW)) bus ();

  prism_sp_fifo_bank #(
    .NFIFOS(NF), .DATA_WIDTH(DW), .DEPTH(DP), .AF_LEVEL(14), .AE_LEVEL(2), .CW(CW)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        wr, rd, fl, ec;
    logic [31:0] wd;
    int          cnt;
    logic        emp, ful, ae, af, ov, un;
    logic [31:0] rdat;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_ch(input string tag, input int ch, input int cnt,
                        input logic emp, input logic ful, input logic ae,
                        input logic af, input logic ov, input logic un,
                        input logic [31:0] rdat);
    chk({tag, ".count"},   32'(bus.data_count[ch]),   32'(cnt));
    chk({tag, ".empty"},   32'(bus.empty[ch]),        32'(emp));
    chk({tag, ".full"},    32'(bus.full[ch]),         32'(ful));
    chk({tag, ".aempty"},  32'(bus.almost_empty[ch]), 32'(ae));
    chk({tag, ".afull"},   32'(bus.almost_full[ch]),  32'(af));
    chk({tag, ".ovf"},     32'(bus.overflow[ch]),     32'(ov));
    chk({tag, ".udf"},     32'(bus.underflow[ch]),    32'(un));
    chk({tag, ".rd_data"}, bus.rd_data[ch],           rdat);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en     = '0;
    bus.rd_en     = '0;
    bus.flush     = '0;
    bus.err_clear = '0;
    bus.wr_data   = '0;
  endtask

  task automatic wr1(input int ch, input logic [31:0] d);
    bus.wr_en[ch]   = 1'b1;
    bus.wr_data[ch] = d;
    step();
    idle_inputs();
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] exp_head;
    ntests = 0;
    nfail  = 0;
    resetn = 1'b0;
    idle_inputs();

    //               wr rd fl ec  wd        cnt emp ful ae af ov un rdat
    vecs[0]  = '{1, 0, 0, 0, 32'hA5, 1, 0, 0, 1, 0, 0, 0, 32'hA5};
    vecs[1]  = '{1, 0, 0, 0, 32'h11, 2, 0, 0, 1, 0, 0, 0, 32'hA5};
    vecs[2]  = '{1, 0, 0, 0, 32'h22, 3, 0, 0, 0, 0, 0, 0, 32'hA5};
    vecs[3]  = '{0, 1, 0, 0, 32'h00, 2, 0, 0, 1, 0, 0, 0, 32'h11};
    vecs[4]  = '{1, 1, 0, 0, 32'h33, 2, 0, 0, 1, 0, 0, 0, 32'h22};
    vecs[5]  = '{0, 1, 0, 0, 32'h00, 1, 0, 0, 1, 0, 0, 0, 32'h33};
    vecs[6]  = '{0, 1, 0, 0, 32'h00, 0, 1, 0, 1, 0, 0, 0, 32'h00};
    vecs[7]  = '{0, 1, 0, 0, 32'h00, 0, 1, 0, 1, 0, 0, 1, 32'h00};
    vecs[8]  = '{0, 0, 0, 1, 32'h00, 0, 1, 0, 1, 0, 0, 0, 32'h00};
    vecs[9]  = '{1, 1, 0, 0, 32'h44, 1, 0, 0, 1, 0, 0, 1, 32'h44};
    vecs[10] = '{0, 0, 0, 1, 32'h00, 1, 0, 0, 1, 0, 0, 0, 32'h44};
    vecs[11] = '{0, 0, 1, 0, 32'h00, 0, 1, 0, 1, 0, 0, 0, 32'h00};

    #12;
    for (int c = 0; c < NF; c++) chk_ch($sformatf("reset.ch%0d", c), c, 0, 1, 0, 1, 0, 0, 0, 0);
    resetn = 1'b1;
    step();

    // Table-driven single-cycle vectors on channel 0.
    for (int i = 0; i < 12; i++) begin
      bus.wr_en[0]     = vecs[i].wr;
      bus.rd_en[0]     = vecs[i].rd;
      bus.flush[0]     = vecs[i].fl;
      bus.err_clear[0] = vecs[i].ec;
      bus.wr_data[0]   = vecs[i].wd;
      step();
      idle_inputs();
      chk_ch($sformatf("vec%0d", i), 0, vecs[i].cnt, vecs[i].emp, vecs[i].ful,
             vecs[i].ae, vecs[i].af, vecs[i].ov, vecs[i].un, vecs[i].rdat);
    end
    for (int c = 1; c < NF; c++) chk_ch($sformatf("isolated.ch%0d", c), c, 0, 1, 0, 1, 0, 0, 0, 0);

    // Fill ch1 to full, overflow on the 17th write, drain in order.
    for (int i = 0; i < DP; i++) begin
      wr1(1, 32'h100 + 32'(i));
      chk($sformatf("fill1.count%0d", i), 32'(bus.data_count[1]), 32'(i + 1));
      chk($sformatf("fill1.afull%0d", i), 32'(bus.almost_full[1]), 32'(i + 1 >= 14));
      chk($sformatf("fill1.full%0d", i), 32'(bus.full[1]), 32'(i == DP - 1));
    end
    wr1(1, 32'hDEAD);
    chk_ch("ovf1", 1, 16, 0, 1, 0, 1, 1, 0, 32'h100);
    for (int i = 0; i < DP; i++) begin
      chk($sformatf("drain1.%0d", i), bus.rd_data[1], 32'h100 + 32'(i));
      bus.rd_en[1] = 1'b1;
      step();
      idle_inputs();
    end
    chk_ch("drain1.end", 1, 0, 1, 0, 1, 0, 1, 0, 0);

    // ch2: simultaneous access while full, then while empty.
    for (int i = 0; i < DP; i++) wr1(2, 32'h200 + 32'(i));
    bus.wr_en[2] = 1'b1; bus.rd_en[2] = 1'b1; bus.wr_data[2] = 32'h2FF;
    step(); idle_inputs();
    chk_ch("rw_full2", 2, 15, 0, 0, 0, 1, 1, 0, 32'h201);
    bus.flush[2] = 1'b1;
    step(); idle_inputs();
    chk_ch("flush2", 2, 0, 1, 0, 1, 0, 1, 0, 0);
    bus.wr_en[2] = 1'b1; bus.rd_en[2] = 1'b1; bus.wr_data[2] = 32'h2AA;
    step(); idle_inputs();
    chk_ch("rw_empty2", 2, 1, 0, 0, 1, 0, 1, 1, 32'h2AA);

    // ch3: 20 writes / 20 reads interleaved so both pointers wrap.
    for (int k = 0; k < 10; k++) begin
      wr1(3, 32'h300 + 32'(k));
      q.push_back(32'h300 + 32'(k));
    end
    for (int k = 0; k < 10; k++) begin
      exp_head = q[0];
      chk($sformatf("wrap3.rw%0d", k), bus.rd_data[3], exp_head);
      bus.wr_en[3] = 1'b1; bus.rd_en[3] = 1'b1; bus.wr_data[3] = 32'h30A + 32'(k);
      step(); idle_inputs();
      void'(q.pop_front());
      q.push_back(32'h30A + 32'(k));
      chk($sformatf("wrap3.cnt%0d", k), 32'(bus.data_count[3]), 32'd10);
    end
    for (int k = 0; k < 10; k++) begin
      exp_head = q[0];
      chk($sformatf("wrap3.rd%0d", k), bus.rd_data[3], exp_head);
      bus.rd_en[3] = 1'b1;
      step(); idle_inputs();
      void'(q.pop_front());
    end
    chk_ch("wrap3.end", 3, 0, 1, 0, 1, 0, 0, 0, 0);

    // ch1 (overflow already set): flush beats simultaneous wr/rd.
    for (int i = 0; i < 5; i++) wr1(1, 32'h400 + 32'(i));
    chk("flush1.pre", 32'(bus.data_count[1]), 32'd5);
    bus.flush[1] = 1'b1; bus.wr_en[1] = 1'b1; bus.rd_en[1] = 1'b1; bus.wr_data[1] = 32'h4FF;
    step(); idle_inputs();
    chk_ch("flush1", 1, 0, 1, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < DP; i++) wr1(1, 32'h500 + 32'(i));
    bus.err_clear[1] = 1'b1; bus.wr_en[1] = 1'b1; bus.wr_data[1] = 32'h5FF;
    step(); idle_inputs();
    chk_ch("setwins1", 1, 16, 0, 1, 0, 1, 1, 0, 32'h500);
    bus.err_clear[1] = 1'b1;
    step(); idle_inputs();
    chk("errclr1", 32'(bus.overflow[1]), 32'd0);

    // Asynchronous reset mid-stream with 9 entries on ch0.
    for (int i = 0; i < 9; i++) wr1(0, 32'h600 + 32'(i));
    chk("pre_rst.count", 32'(bus.data_count[0]), 32'd9);
    #3;
    resetn = 1'b0;
    #1;
    chk_ch("async_rst0", 0, 0, 1, 0, 1, 0, 0, 0, 0);
    chk_ch("async_rst1", 1, 0, 1, 0, 1, 0, 0, 0, 0);
    chk_ch("async_rst2", 2, 0, 1, 0, 1, 0, 0, 0, 0);
    #2;
    resetn = 1'b1;
    wr1(0, 32'h5A);
    chk_ch("post_rst0", 0, 1, 0, 0, 1, 0, 0, 0, 32'h5A);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
